// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, branch squash,
// memory wait states and the halt drain, plus a saturating stall-cycle counter.
//
// state  | meaning
// RUN    | normal issue, load-use/halt/imem checks live
// LSTALL | extra load-use bubbles beyond the first
// DRAIN  | halt decoded, older instructions retiring
// HALT   | core stopped until reset
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W        = 3,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int HALT_DRAIN        = 3,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic                  use_rs_id,
    input  logic                  use_rt_id,
    input  logic                  memread_ex,
    input  logic [REG_ADDR_W-1:0] wreg_ex,
    input  logic                  branch_taken_ex,
    input  logic                  halt_id,
    input  logic                  imem_busy,
    input  logic                  dmem_busy,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  ifid_flush,
    output logic                  idex_stall,
    output logic                  idex_flush,
    output logic                  exmem_stall,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int CMAX = (LOAD_STALL_CYCLES > HALT_DRAIN) ? LOAD_STALL_CYCLES : HALT_DRAIN;
    localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

    typedef enum logic [1:0] {RUN, LSTALL, DRAIN, HALT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          load_use;
    logic          branch_act;

    // R0 is hardwired, so a load targeting it never creates a real dependency
    assign load_use = memread_ex && (wreg_ex != '0) &&
                      ((use_rs_id && (rs_id == wreg_ex)) ||
                       (use_rt_id && (rt_id == wreg_ex)));

    assign branch_act = branch_taken_ex && ((state == RUN) || (state == LSTALL));

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        halted      = 1'b0;
        if (!rst) begin
            if (state == HALT) begin
                halted      = 1'b1;
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
            end else if (dmem_busy) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
            end else if (branch_act) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if ((state != RUN) || load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end else if (halt_id) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
            end else if (imem_busy) begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!dmem_busy) begin
                case (state)
                    RUN: begin
                        if (!branch_taken_ex) begin
                            if (load_use) begin
                                if (LOAD_STALL_CYCLES > 1) begin
                                    state <= LSTALL;
                                    cnt   <= CW'(LOAD_STALL_CYCLES - 1);
                                end
                            end else if (halt_id) begin
                                state <= DRAIN;
                                cnt   <= CW'(HALT_DRAIN - 1);
                            end
                        end
                    end
                    LSTALL: begin
                        if (branch_taken_ex || (cnt == CW'(1))) begin
                            state <= RUN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    DRAIN: begin
                        if (cnt == '0)
                            state <= HALT;
                        else
                            cnt <= cnt - CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: four instances with different stall
// depths / counter widths share one stimulus stream.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rs_id = '0, rt_id = '0, wreg_ex = '0;
    logic       use_rs_id = 0, use_rt_id = 0, memread_ex = 0, branch_taken_ex = 0;
    logic       halt_id = 0, imem_busy = 0, dmem_busy = 0;

    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, halted}
    logic [6:0]  o1, o2, o3, os;
    logic [15:0] sc1, sc2, sc3;
    logic [3:0]  scs;

    localparam logic [6:0] NONE   = 7'b0000000;
    localparam logic [6:0] LU     = 7'b1100100;
    localparam logic [6:0] BR     = 7'b0010100;
    localparam logic [6:0] DM     = 7'b1101010;
    localparam logic [6:0] HID    = 7'b1100000;
    localparam logic [6:0] HALTED = 7'b1101011;
    localparam logic [6:0] IMEM   = 7'b1010000;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1)) d1 (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id),
        .use_rt_id(use_rt_id), .memread_ex(memread_ex), .wreg_ex(wreg_ex),
        .branch_taken_ex(branch_taken_ex), .halt_id(halt_id), .imem_busy(imem_busy),
        .dmem_busy(dmem_busy), .pc_stall(o1[6]), .ifid_stall(o1[5]), .ifid_flush(o1[4]),
        .idex_stall(o1[3]), .idex_flush(o1[2]), .exmem_stall(o1[1]), .halted(o1[0]),
        .stall_cnt(sc1));

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2)) d2 (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id),
        .use_rt_id(use_rt_id), .memread_ex(memread_ex), .wreg_ex(wreg_ex),
        .branch_taken_ex(branch_taken_ex), .halt_id(halt_id), .imem_busy(imem_busy),
        .dmem_busy(dmem_busy), .pc_stall(o2[6]), .ifid_stall(o2[5]), .ifid_flush(o2[4]),
        .idex_stall(o2[3]), .idex_flush(o2[2]), .exmem_stall(o2[1]), .halted(o2[0]),
        .stall_cnt(sc2));

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) d3 (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id),
        .use_rt_id(use_rt_id), .memread_ex(memread_ex), .wreg_ex(wreg_ex),
        .branch_taken_ex(branch_taken_ex), .halt_id(halt_id), .imem_busy(imem_busy),
        .dmem_busy(dmem_busy), .pc_stall(o3[6]), .ifid_stall(o3[5]), .ifid_flush(o3[4]),
        .idex_stall(o3[3]), .idex_flush(o3[2]), .exmem_stall(o3[1]), .halted(o3[0]),
        .stall_cnt(sc3));

    pipe_hazard_ctrl #(.CNT_W(4)) ds (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id),
        .use_rt_id(use_rt_id), .memread_ex(memread_ex), .wreg_ex(wreg_ex),
        .branch_taken_ex(branch_taken_ex), .halt_id(halt_id), .imem_busy(imem_busy),
        .dmem_busy(dmem_busy), .pc_stall(os[6]), .ifid_stall(os[5]), .ifid_flush(os[4]),
        .idex_stall(os[3]), .idex_flush(os[2]), .exmem_stall(os[1]), .halted(os[0]),
        .stall_cnt(scs));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rs_id = '0; rt_id = '0; wreg_ex = '0;
        use_rs_id = 0; use_rt_id = 0; memread_ex = 0; branch_taken_ex = 0;
        halt_id = 0; imem_busy = 0; dmem_busy = 0;
    endtask

    task automatic set_lu();
        memread_ex = 1; wreg_ex = 3'd3; rs_id = 3'd3; use_rs_id = 1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        #2;
        rst = 0;
        #1;
    endtask

    initial begin
        // outputs forced low while reset is held, even with hazards present
        set_lu();
        imem_busy = 1;
        #2;
        check("reset_out", {9'd0, o1}, {9'd0, NONE});
        check("reset_cnt", sc1, 16'd0);
        clear_in();
        cyc();
        rst = 0;
        #1;

        // single-cycle load-use
        set_lu();
        #1;
        check("lu_out", {9'd0, o1}, {9'd0, LU});
        cyc();
        clear_in();
        #1;
        check("lu_after", {9'd0, o1}, {9'd0, NONE});
        check("lu_cnt", sc1, 16'd1);
        check("lu2_lstall", {9'd0, o2}, {9'd0, LU});
        check("lu3_lstall1", {9'd0, o3}, {9'd0, LU});
        cyc();
        check("lu2_run", {9'd0, o2}, {9'd0, NONE});
        check("lu3_lstall2", {9'd0, o3}, {9'd0, LU});
        cyc();
        check("lu3_run", {9'd0, o3}, {9'd0, NONE});
        check("lu3_cnt", sc3, 16'd3);

        // R0 destination and unused source operand
        memread_ex = 1; wreg_ex = 3'd0; rs_id = 3'd0; use_rs_id = 1;
        #1;
        check("r0_nostall", {9'd0, o1}, {9'd0, NONE});
        wreg_ex = 3'd5; rs_id = 3'd5; rt_id = 3'd5; use_rs_id = 0; use_rt_id = 0;
        #1;
        check("nouse_nostall", {9'd0, o1}, {9'd0, NONE});
        use_rt_id = 1;
        #1;
        check("rt_stall", {9'd0, o1}, {9'd0, LU});
        clear_in();
        #1;

        // branch overrides load-use and halt
        set_lu();
        branch_taken_ex = 1;
        halt_id = 1;
        #1;
        check("br_over_lu", {9'd0, o1}, {9'd0, BR});
        check("br_over_lu3", {9'd0, o3}, {9'd0, BR});
        cyc();
        clear_in();
        #1;
        check("br_stay_run", {9'd0, o1}, {9'd0, NONE});
        check("br_stay_run3", {9'd0, o3}, {9'd0, NONE});

        // branch aborts LSTALL
        set_lu();
        cyc();
        clear_in();
        #1;
        check("br_lstall_pre", {9'd0, o3}, {9'd0, LU});
        branch_taken_ex = 1;
        #1;
        check("br_in_lstall", {9'd0, o3}, {9'd0, BR});
        cyc();
        clear_in();
        #1;
        check("br_lstall_exit", {9'd0, o3}, {9'd0, NONE});

        // dmem_busy freezes LSTALL
        do_reset();
        set_lu();
        #1;
        check("dm_lu", {9'd0, o2}, {9'd0, LU});
        cyc();
        clear_in();
        dmem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("dm_stall", {9'd0, o2}, {9'd0, DM});
            cyc();
        end
        dmem_busy = 0;
        #1;
        check("dm_lstall_rem", {9'd0, o2}, {9'd0, LU});
        cyc();
        check("dm_run", {9'd0, o2}, {9'd0, NONE});
        check("dm_cnt", sc2, 16'd6);

        // halt drain, hold, then async reset
        do_reset();
        halt_id = 1;
        #1;
        check("halt_id", {9'd0, o1}, {9'd0, HID});
        cyc();
        halt_id = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("drain", {9'd0, o1}, {9'd0, LU});
            cyc();
        end
        check("halted", {9'd0, o1}, {9'd0, HALTED});
        cyc();
        check("halted_hold", {9'd0, o1}, {9'd0, HALTED});
        check("halt_cnt", sc1, 16'd5);
        rst = 1;
        #1;
        check("halt_rst_out", {9'd0, o1}, {9'd0, NONE});
        check("halt_rst_cnt", sc1, 16'd0);
        rst = 0;
        #1;
        check("halt_rst_run", {9'd0, o1}, {9'd0, NONE});

        // saturation on the narrow counter
        do_reset();
        imem_busy = 1;
        #1;
        check("imem_out", {9'd0, os}, {9'd0, IMEM});
        for (int i = 0; i < 20; i++) cyc();
        check("sat_15", {12'd0, scs}, 16'd15);
        check("wide_20", sc1, 16'd20);
        cyc();
        check("sat_hold", {12'd0, scs}, 16'd15);
        clear_in();
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage 16-bit pipelined core.
- Drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC write enable.
- Resolves load-use hazards, taken-branch squashes, instruction/data memory wait states and the halt drain.
- Sits beside the ID-stage decoder and takes hazard inputs from the ID, EX and MEM stages.

Parameters:
- REG_ADDR_W, 3, register-index width (8 GPRs).
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3).
- HALT_DRAIN, 3, cycles after halt decode before `halted` asserts (lets EX/MEM/WB retire).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rs_id  in  REG_ADDR_W  ID-stage source register 1
- rt_id  in  REG_ADDR_W  ID-stage source register 2
- use_rs_id  in  1  ID instruction reads rs
- use_rt_id  in  1  ID instruction reads rt
- memread_ex  in  1  EX-stage instruction is a load
- wreg_ex  in  REG_ADDR_W  EX-stage destination register
- branch_taken_ex  in  1  EX resolved a taken branch/jump
- halt_id  in  1  ID holds HALT opcode
- imem_busy  in  1  instruction memory not ready this cycle
- dmem_busy  in  1  data memory not ready this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  zero IF/ID (NOP)
- idex_stall  out  1  hold ID/EX
- idex_flush  out  1  inject bubble into ID/EX
- exmem_stall  out  1  hold EX/MEM
- halted  out  1  core stopped
- stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating

Behaviour:
- Reset (async, rst=1):
  - state=RUN, load counter=0, drain counter=0, stall_cnt=0, halted=0.
  - All stall/flush outputs are 0 while reset is held.
- Outputs are combinational from the current state and inputs. State, counters and stall_cnt are registered.
- States and transitions:
  - RUN:
    - Load-use hazard = memread_ex && ((use_rs_id && rs_id==wreg_ex) || (use_rt_id && rt_id==wreg_ex)) && wreg_ex!=0 (R0 hardwired).
    - On hazard: pc_stall=ifid_stall=1, idex_flush=1 this cycle. If LOAD_STALL_CYCLES>1, go to LSTALL with counter=LOAD_STALL_CYCLES-1.
    - On halt_id (no higher-priority event): pc_stall=ifid_stall=1; go to DRAIN with counter=HALT_DRAIN-1.
  - LSTALL: pc_stall=ifid_stall=idex_flush=1; decrement counter; at counter==1 return to RUN.
  - DRAIN:
    - pc_stall=ifid_stall=1, idex_flush=1 (later stages keep retiring).
    - Decrement counter; at 0 go to HALT.
  - HALT: halted=1, pc_stall=ifid_stall=idex_stall=exmem_stall=1. Exits only via rst.
- Priority, highest first, evaluated every cycle:
  1. dmem_busy: pc_stall=ifid_stall=idex_stall=exmem_stall=1, no flushes. State and counters frozen.
  2. branch_taken_ex: ifid_flush=idex_flush=1, pc_stall=0. Overrides load-use and halt_id, since the ID instruction is wrong-path. In LSTALL, abort to RUN. In DRAIN/HALT a branch cannot occur and is ignored.
  3. Load-use (RUN) or LSTALL/DRAIN actions.
  4. imem_busy: pc_stall=1, ifid_flush=1 (bubble into ID); downstream flows normally.
- Flush and stall asserted on the same register: flush wins. The register block must implement flush>stall.
- stall_cnt increments each cycle pc_stall=1 and rst=0. It saturates at all-ones and never wraps.
- rst asserted mid-LSTALL/DRAIN/HALT returns to RUN immediately and asynchronously.

Test Plan:
- Load-use: memread_ex=1, wreg_ex=3, rs_id=3, use_rs_id=1 → one cycle pc_stall=ifid_stall=idex_flush=1; next cycle (hazard gone) all 0; stall_cnt=1.
- R0/no-use: wreg_ex=0 with rs_id=0, or rt_id match with use_rt_id=0 → no stall, outputs 0.
- Branch over load-use: branch_taken_ex=1 together with a load-use match → ifid_flush=idex_flush=1, pc_stall=0, state stays RUN. With LOAD_STALL_CYCLES=3, a branch in LSTALL returns to RUN the next cycle.
- dmem_busy for 4 cycles during LSTALL (LOAD_STALL_CYCLES=2) → all four stalls=1 and counter frozen; after release, one remaining LSTALL cycle, then RUN; stall_cnt=+6.
- Halt: halt_id=1 in RUN → 3 drain cycles with idex_flush=1, then halted=1 held. rst pulse mid-HALT → halted=0 immediately, stall_cnt=0.
- Saturation: CNT_W=4, hold imem_busy 20 cycles → stall_cnt reaches 15 and stays 15.
